servant_spi_arbiter: RTL and testbench

SERVANT_SPI_ARBITER -- requirements
Module: servant_spi_arbiter

---
 rtl/servant_spi_arbiter.sv | 152 +++++++++++++++
 tb/tb_servant_spi_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_spi_arbiter.sv
// Arbitrates the servant ibus and dbus Wishbone requesters onto one SPI-master port.
// Issues a config write after every reset, then grants round-robin with abort and timeout recovery.
module servant_spi_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 24,
    parameter int unsigned TIMEOUT       = 4096
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-3:0] ibus_adr,
    input  logic                     ibus_cyc,
    output logic                     ibus_ack,
    input  logic [ADDRESS_WIDTH-3:0] dbus_adr,
    input  logic [31:0]              dbus_dat,
    input  logic [3:0]               dbus_sel,
    input  logic                     dbus_we,
    input  logic                     dbus_cyc,
    output logic                     dbus_ack,
    output logic [31:0]              rdt,
    output logic [ADDRESS_WIDTH-3:0] s_adr,
    output logic [31:0]              s_dat,
    output logic [3:0]               s_sel,
    output logic                     s_we,
    output logic                     s_cyc,
    input  logic [31:0]              s_rdt,
    input  logic                     s_ack,
    output logic                     timeout_err,
    output logic [1:0]               grant
);
    localparam int unsigned     CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             last_dbus;
    logic             last_dbus_nxt;
    logic             owner_dbus;
    logic             owner_dbus_nxt;

    logic pick_dbus;
    logic owner_cyc;
    logic busy;
    logic end_ack;
    logic end_abort;
    logic end_timeout;

    // Round-robin: dbus wins a tie only if ibus was the last one granted.
    assign pick_dbus   = dbus_cyc & (~ibus_cyc | ~last_dbus);
    assign owner_cyc   = owner_dbus ? dbus_cyc : ibus_cyc;
    assign busy        = (state == ST_BUSY);
    assign end_ack     = busy & owner_cyc & s_ack;
    assign end_abort   = busy & ~owner_cyc;
    assign end_timeout = busy & owner_cyc & ~s_ack & (wait_cnt == CNT_LAST);

    assign rdt = s_rdt;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_INIT;
            wait_cnt   <= '0;
            last_dbus  <= 1'b1;
            owner_dbus <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            last_dbus  <= last_dbus_nxt;
            owner_dbus <= owner_dbus_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        last_dbus_nxt  = last_dbus;
        owner_dbus_nxt = owner_dbus;
        case (state)
            ST_INIT: begin
                if (s_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (ibus_cyc | dbus_cyc) begin
                    state_nxt      = ST_BUSY;
                    wait_cnt_nxt   = '0;
                    owner_dbus_nxt = pick_dbus;
                    last_dbus_nxt  = pick_dbus;
                end
            end
            ST_BUSY: begin
                if (end_ack | end_abort | end_timeout) begin
                    state_nxt = ST_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Output logic: downstream mux, ack routing, grant and timeout pulse
    always_comb begin
        s_adr       = '0;
        s_dat       = '0;
        s_sel       = '0;
        s_we        = 1'b0;
        s_cyc       = 1'b0;
        ibus_ack    = 1'b0;
        dbus_ack    = 1'b0;
        grant       = 2'b00;
        timeout_err = 1'b0;
        case (state)
            ST_INIT: begin
                // Config write; held off while reset is asserted.
                s_cyc = ~reset;
                s_we  = 1'b1;
            end
            ST_BUSY: begin
                timeout_err = end_timeout;
                if (owner_dbus) begin
                    grant    = 2'b10;
                    s_adr    = dbus_adr;
                    s_dat    = dbus_dat;
                    s_sel    = dbus_sel;
                    s_we     = dbus_we;
                    s_cyc    = dbus_cyc;
                    dbus_ack = end_ack;
                end else begin
                    grant    = 2'b01;
                    s_adr    = ibus_adr;
                    s_sel    = 4'hF;
                    s_cyc    = ibus_cyc;
                    ibus_ack = end_ack;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_servant_spi_arbiter.sv
// Scoreboard bench for servant_spi_arbiter: expected downstream transactions are queued
// when requests are raised and checked at the cycle the downstream model acknowledges.
module tb_servant_spi_arbiter;
    localparam int unsigned AW = 24;
    localparam int unsigned TO = 16;
    localparam int unsigned WA = AW - 2;

    typedef struct {
        logic [WA-1:0] adr;
        logic [31:0]   dat;
        logic [3:0]    sel;
        logic          we;
        logic [1:0]    who;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [WA-1:0] ibus_adr = '0;
    logic          ibus_cyc = 1'b0;
    logic          ibus_ack;
    logic [WA-1:0] dbus_adr = '0;
    logic [31:0]   dbus_dat = '0;
    logic [3:0]    dbus_sel = '0;
    logic          dbus_we = 1'b0;
    logic          dbus_cyc = 1'b0;
    logic          dbus_ack;
    logic [31:0]   rdt;
    logic [WA-1:0] s_adr;
    logic [31:0]   s_dat;
    logic [3:0]    s_sel;
    logic          s_we;
    logic          s_cyc;
    logic [31:0]   s_rdt = '0;
    logic          s_ack = 1'b0;
    logic          timeout_err;
    logic [1:0]    grant;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_wait;
    logic [31:0] rdt_drv;

    servant_spi_arbiter #(
        .ADDRESS_WIDTH(AW),
        .TIMEOUT      (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ibus_adr   (ibus_adr),
        .ibus_cyc   (ibus_cyc),
        .ibus_ack   (ibus_ack),
        .dbus_adr   (dbus_adr),
        .dbus_dat   (dbus_dat),
        .dbus_sel   (dbus_sel),
        .dbus_we    (dbus_we),
        .dbus_cyc   (dbus_cyc),
        .dbus_ack   (dbus_ack),
        .rdt        (rdt),
        .s_adr      (s_adr),
        .s_dat      (s_dat),
        .s_sel      (s_sel),
        .s_we       (s_we),
        .s_cyc      (s_cyc),
        .s_rdt      (s_rdt),
        .s_ack      (s_ack),
        .timeout_err(timeout_err),
        .grant      (grant)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_init();
        exp_t e;
        e.adr = '0; e.dat = '0; e.sel = 4'h0; e.we = 1'b1; e.who = 2'b00;
        sb.push_back(e);
    endtask

    task automatic push_i(input logic [WA-1:0] adr);
        exp_t e;
        e.adr = adr; e.dat = '0; e.sel = 4'hF; e.we = 1'b0; e.who = 2'b01;
        sb.push_back(e);
    endtask

    task automatic push_d(input logic [WA-1:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic we);
        exp_t e;
        e.adr = adr; e.dat = dat; e.sel = sel; e.we = we; e.who = 2'b10;
        sb.push_back(e);
    endtask

    // Downstream model: waits for s_cyc, stays quiet lat cycles, acks on cycle lat+1.
    task automatic serve(input int lat);
        bit   seen = 1'b0;
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock); #2;
            if (s_cyc) begin
                seen = 1'b1;
                break;
            end
        end
        check("s_cyc_start", 64'(seen), 64'd1);
        if (!seen) return;
        for (int i = 1; i <= lat; i++) begin
            check("wait_quiet", 64'({ibus_ack, dbus_ack, timeout_err}), 64'd0);
            if (i < lat) begin
                @(negedge clock); #2;
            end
        end
        @(negedge clock);
        rdt_drv = $urandom;
        s_rdt   = rdt_drv;
        s_ack   = 1'b1;
        #2;
        if (sb.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("s_adr", 64'(s_adr), 64'(e.adr));
            check("s_dat", 64'(s_dat), 64'(e.dat));
            check("s_sel", 64'(s_sel), 64'(e.sel));
            check("s_we", 64'(s_we), 64'(e.we));
            check("s_cyc_ack", 64'(s_cyc), 64'd1);
            check("grant", 64'(grant), 64'(e.who));
            check("ibus_ack", 64'(ibus_ack), 64'(e.who[0]));
            check("dbus_ack", 64'(dbus_ack), 64'(e.who[1]));
            check("to_at_ack", 64'(timeout_err), 64'd0);
            check("rdt", 64'(rdt), 64'(rdt_drv));
        end
        @(negedge clock);
        s_ack = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, 64'(grant), 64'd0);
        check({tag, "_scyc"}, 64'(s_cyc), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state, with requester and downstream activity that must be ignored
        repeat (2) @(negedge clock);
        ibus_cyc = 1'b1;
        s_ack    = 1'b1;
        #2;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_acks", 64'({ibus_ack, dbus_ack}), 64'd0);
        check("rst_scyc", 64'(s_cyc), 64'd0);
        check("rst_to", 64'(timeout_err), 64'd0);

        // INIT config write acked after 5 cycles; ibus_cyc held high is ignored
        @(negedge clock);
        s_ack = 1'b0;
        reset = 1'b0;
        push_init();
        serve(5);
        ibus_cyc = 1'b0;
        #2 check_idle("post_init");

        // Simultaneous requests: last grant is dbus after reset, so ibus goes first
        @(negedge clock);
        ibus_adr = 22'h001234; ibus_cyc = 1'b1;
        dbus_adr = 22'h000055; dbus_dat = 32'hCAFEF00D; dbus_sel = 4'hC; dbus_we = 1'b0;
        dbus_cyc = 1'b1;
        push_i(22'h001234);
        push_d(22'h000055, 32'hCAFEF00D, 4'hC, 1'b0);
        serve(2);
        ibus_cyc = 1'b0;
        #2 check_idle("gap");
        serve(3);
        dbus_cyc = 1'b0;

        // Lone ibus request, then a tie which dbus must now win
        ibus_adr = 22'h002222; ibus_cyc = 1'b1;
        push_i(22'h002222);
        serve(1);
        ibus_cyc = 1'b0;
        ibus_adr = 22'h004444; ibus_cyc = 1'b1;
        dbus_adr = 22'h003333; dbus_dat = 32'h0BADF00D; dbus_sel = 4'h5; dbus_we = 1'b1;
        dbus_cyc = 1'b1;
        push_d(22'h003333, 32'h0BADF00D, 4'h5, 1'b1);
        push_i(22'h004444);
        serve(2);
        dbus_cyc = 1'b0;
        serve(2);
        ibus_cyc = 1'b0;

        // dbus write at top address, acked on the same cycle the timeout would fire
        dbus_adr = 22'h3FFFFF; dbus_dat = 32'hDEADBEEF; dbus_sel = 4'h3; dbus_we = 1'b1;
        dbus_cyc = 1'b1;
        push_d(22'h3FFFFF, 32'hDEADBEEF, 4'h3, 1'b1);
        serve(TO - 1);
        dbus_cyc = 1'b0;

        // No ack: timeout pulse on BUSY cycle TO, no ack, back to idle
        ibus_adr = 22'h000ABC; ibus_cyc = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock); #2;
            if (s_cyc) break;
        end
        n_wait = 1;
        while (!timeout_err && n_wait < 3 * TO) begin
            @(negedge clock); #2;
            n_wait++;
        end
        check("to_cycle", 64'(n_wait), 64'(TO));
        check("to_acks", 64'({ibus_ack, dbus_ack}), 64'd0);
        check("to_grant", 64'(grant), 64'd1);
        @(negedge clock);
        ibus_cyc = 1'b0;
        #2 check_idle("post_to");
        check("to_pulse_end", 64'(timeout_err), 64'd0);

        // Stray s_ack in IDLE is ignored
        @(negedge clock);
        s_ack = 1'b1;
        #2;
        check("idle_ack", 64'({ibus_ack, dbus_ack, timeout_err}), 64'd0);
        @(negedge clock);
        s_ack = 1'b0;
        #2 check_idle("idle_stray");

        // dbus abort mid-transaction, then a normal ibus transaction
        @(negedge clock);
        dbus_adr = 22'h000100; dbus_we = 1'b0; dbus_sel = 4'hF; dbus_cyc = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock); #2;
            if (s_cyc) break;
        end
        check("abort_grant", 64'(grant), 64'd2);
        repeat (2) @(negedge clock);
        dbus_cyc = 1'b0;
        #2;
        check("abort_scyc", 64'(s_cyc), 64'd0);
        check("abort_ack", 64'({ibus_ack, dbus_ack}), 64'd0);
        @(negedge clock);
        ibus_adr = 22'h005555; ibus_cyc = 1'b1;
        push_i(22'h005555);
        #2 check_idle("post_abort");
        serve(3);
        ibus_cyc = 1'b0;

        // Reset mid-BUSY: outputs drop at once and INIT repeats
        dbus_adr = 22'h000200; dbus_we = 1'b0; dbus_cyc = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock); #2;
            if (s_cyc) break;
        end
        @(negedge clock);
        reset = 1'b1;
        s_ack = 1'b1;
        #2;
        check("mid_rst_grant", 64'(grant), 64'd0);
        check("mid_rst_acks", 64'({ibus_ack, dbus_ack}), 64'd0);
        check("mid_rst_scyc", 64'(s_cyc), 64'd0);
        check("mid_rst_to", 64'(timeout_err), 64'd0);
        @(negedge clock);
        dbus_cyc = 1'b0;
        s_ack    = 1'b0;
        reset    = 1'b0;
        push_init();
        serve(5);
        #2 check_idle("post_reinit");

        // Normal traffic after the repeated INIT
        @(negedge clock);
        dbus_adr = 22'h000321; dbus_dat = 32'h12345678; dbus_sel = 4'h6; dbus_we = 1'b1;
        dbus_cyc = 1'b1;
        push_d(22'h000321, 32'h12345678, 4'h6, 1'b1);
        serve(4);
        dbus_cyc = 1'b0;
        #2 check_idle("final");

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
